cache_request_initiator: RTL and testbench

//  Requester-side endpoint of the cache-access protocol: queues load/store requests from a processing element and drives them onto a router port as memRead/memWrite pulses.

---
 rtl/cache_request_initiator.sv | 159 +++++++++++++++
 tb/tb_cache_request_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_request_initiator.sv
// Requester-side cache-access endpoint: queues PE loads/stores, issues them to the router,
// and matches returned read data against this node's address with timeout/retry.
module cache_request_initiator #(
    parameter int DATA_WIDTH               = 32,
    parameter int CACHE_BANK_ADDRESS_WIDTH = 10,
    parameter int NETWORK_ADDRESS_WIDTH    = 8,
    parameter int MY_ADDRESS               = 0,
    parameter int FIFO_DEPTH               = 4,
    parameter int TIMEOUT_CYCLES           = 64,
    parameter int MAX_RETRIES              = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                coreReq_valid,
    output logic                                coreReq_ready,
    input  logic                                coreReq_write,
    input  logic [NETWORK_ADDRESS_WIDTH-1:0]    coreReq_bankNode,
    input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] coreReq_address,
    input  logic [DATA_WIDTH-1:0]               coreReq_data,
    output logic                                coreResp_valid,
    output logic                                coreResp_error,
    output logic [DATA_WIDTH-1:0]               coreResp_data,
    output logic                                writeDone,
    output logic                                busy,
    output logic [NETWORK_ADDRESS_WIDTH-1:0]    targetAddressOut,
    output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
    output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
    output logic                                memReadOut,
    output logic                                memWriteOut,
    output logic [DATA_WIDTH-1:0]               dataOut,
    input  logic                                netReady,
    input  logic                                readReadyIn,
    input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
    input  logic [DATA_WIDTH-1:0]               cacheDataIn
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [NETWORK_ADDRESS_WIDTH-1:0] MY_ADDR = NETWORK_ADDRESS_WIDTH'(MY_ADDRESS);

    typedef struct packed {
        logic                                write;
        logic [NETWORK_ADDRESS_WIDTH-1:0]    node;
        logic [CACHE_BANK_ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]               data;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, nextState;
    req_t            fifoMem [FIFO_DEPTH];
    req_t            pending;
    logic [PW-1:0]   wrPtr, rdPtr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry;
    logic            respValidQ, respErrorQ, writeDoneQ;
    logic [DATA_WIDTH-1:0] respDataQ;

    logic push, pop, match, timeoutHit, issueOn;
    logic respValidNext, respErrorNext, respLoad, writeDoneNext, retryInc;

    assign coreReq_ready = ~reset & (count != CW'(FIFO_DEPTH));
    assign push          = coreReq_valid & coreReq_ready;
    assign pop           = (state == IDLE) & (count != '0);
    assign match         = readReadyIn & (requesterAddressIn == MY_ADDR);
    assign timeoutHit    = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        nextState     = state;
        respValidNext = 1'b0;
        respErrorNext = 1'b0;
        respLoad      = 1'b0;
        writeDoneNext = 1'b0;
        retryInc      = 1'b0;
        case (state)
            IDLE:  if (pop) nextState = ISSUE;
            ISSUE: if (netReady) begin
                if (pending.write) begin
                    writeDoneNext = 1'b1;
                    nextState     = IDLE;
                end else begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                // a match in the timeout cycle still completes normally
                if (match) begin
                    respValidNext = 1'b1;
                    respLoad      = 1'b1;
                    nextState     = IDLE;
                end else if (timeoutHit) begin
                    if (retry < RW'(MAX_RETRIES)) begin
                        retryInc  = 1'b1;
                        nextState = ISSUE;
                    end else begin
                        respValidNext = 1'b1;
                        respErrorNext = 1'b1;
                        respLoad      = 1'b1;
                        nextState     = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= '{coreReq_write, coreReq_bankNode, coreReq_address, coreReq_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            pending    <= '0;
            timer      <= '0;
            retry      <= '0;
            respValidQ <= 1'b0;
            respErrorQ <= 1'b0;
            respDataQ  <= '0;
            writeDoneQ <= 1'b0;
        end else begin
            state <= nextState;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr   <= rdPtr + 1'b1;
                pending <= fifoMem[rdPtr];
                retry   <= '0;
            end else if (retryInc) begin
                retry <= retry + 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            timer      <= (state == WAIT) ? timer + 1'b1 : '0;
            respValidQ <= respValidNext;
            respErrorQ <= respErrorNext;
            writeDoneQ <= writeDoneNext;
            if (respLoad) respDataQ <= match ? cacheDataIn : '0;
        end
    end

    // everything reads as zero while reset is held, even before the clock edge takes it
    assign issueOn             = ~reset & (state == ISSUE);
    assign memReadOut          = issueOn & ~pending.write;
    assign memWriteOut         = issueOn & pending.write;
    assign targetAddressOut    = issueOn ? pending.node : '0;
    assign cacheAddressOut     = issueOn ? pending.addr : '0;
    assign dataOut             = (issueOn & pending.write) ? pending.data : '0;
    assign requesterAddressOut = reset ? '0 : MY_ADDR;
    assign busy                = ~reset & ((count != '0) | (state != IDLE));
    assign coreResp_valid      = ~reset & respValidQ;
    assign coreResp_error      = ~reset & respErrorQ;
    assign coreResp_data       = reset ? '0 : respDataQ;
    assign writeDone           = ~reset & writeDoneQ;
endmodule

// File: tb/tb_cache_request_initiator.sv
// Scoreboard bench for cache_request_initiator: expected issues/completions are queued at
// stimulus time and popped by a monitor as the DUT produces them.
module tb_cache_request_initiator;
    localparam int TMO = 64;
    localparam logic [7:0] MY = 8'd5;

    logic clk = 1'b0, reset = 1'b1;
    logic coreReq_valid = 1'b0, coreReq_ready, coreReq_write = 1'b0;
    logic [7:0] coreReq_bankNode = '0;
    logic [9:0] coreReq_address = '0;
    logic [31:0] coreReq_data = '0;
    logic coreResp_valid, coreResp_error, writeDone, busy;
    logic [31:0] coreResp_data, dataOut;
    logic [7:0] targetAddressOut, requesterAddressOut;
    logic [9:0] cacheAddressOut;
    logic memReadOut, memWriteOut;
    logic netReady = 1'b0, readReadyIn = 1'b0;
    logic [7:0] requesterAddressIn = '0;
    logic [31:0] cacheDataIn = '0;

    int nCmp = 0, nBad = 0, cyc = 0;

    typedef struct { bit w; logic [7:0] node; logic [9:0] addr; logic [31:0] data; } iss_t;
    typedef struct { bit w; logic [31:0] data; bit err; } rsp_t;
    iss_t issueQ[$];
    rsp_t respQ[$];
    iss_t ie;
    rsp_t re;

    cache_request_initiator #(.MY_ADDRESS(5), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(2)) dut (
        .clk(clk), .reset(reset),
        .coreReq_valid(coreReq_valid), .coreReq_ready(coreReq_ready), .coreReq_write(coreReq_write),
        .coreReq_bankNode(coreReq_bankNode), .coreReq_address(coreReq_address), .coreReq_data(coreReq_data),
        .coreResp_valid(coreResp_valid), .coreResp_error(coreResp_error), .coreResp_data(coreResp_data),
        .writeDone(writeDone), .busy(busy),
        .targetAddressOut(targetAddressOut), .requesterAddressOut(requesterAddressOut),
        .cacheAddressOut(cacheAddressOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
        .dataOut(dataOut), .netReady(netReady), .readReadyIn(readReadyIn),
        .requesterAddressIn(requesterAddressIn), .cacheDataIn(cacheDataIn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // scoreboard monitor: accepted router requests and PE completions, in order
    always @(negedge clk) if (!reset) begin
        if ((memReadOut || memWriteOut) && netReady) begin
            nCmp++;
            if (issueQ.size() == 0) begin
                nBad++;
                $display("FAIL issue_unexpected: got node=%0d addr=%h, required no issue", targetAddressOut, cacheAddressOut);
            end else begin
                ie = issueQ.pop_front();
                if ({memWriteOut, memReadOut, targetAddressOut, cacheAddressOut, requesterAddressOut} !==
                        {ie.w, !ie.w, ie.node, ie.addr, MY} || (ie.w && dataOut !== ie.data)) begin
                    nBad++;
                    $display("FAIL issue: got w=%b r=%b node=%0d addr=%h req=%0d data=%h, required w=%b node=%0d addr=%h req=%0d data=%h",
                             memWriteOut, memReadOut, targetAddressOut, cacheAddressOut, requesterAddressOut, dataOut,
                             ie.w, ie.node, ie.addr, MY, ie.data);
                end
            end
        end
        if (coreResp_valid || writeDone) begin
            nCmp++;
            if (respQ.size() == 0) begin
                nBad++;
                $display("FAIL resp_unexpected: got valid=%b writeDone=%b data=%h, required none", coreResp_valid, writeDone, coreResp_data);
            end else begin
                re = respQ.pop_front();
                if (re.w !== writeDone || (!re.w && (coreResp_data !== re.data || coreResp_error !== re.err))) begin
                    nBad++;
                    $display("FAIL resp: got wd=%b data=%h err=%b, required wd=%b data=%h err=%b",
                             writeDone, coreResp_data, coreResp_error, re.w, re.data, re.err);
                end
            end
        end
    end

    task automatic push_req(input bit w, input logic [7:0] node, input logic [9:0] addr, input logic [31:0] d);
        int n = 0;
        coreReq_valid = 1'b1; coreReq_write = w; coreReq_bankNode = node;
        coreReq_address = addr; coreReq_data = d;
        @(negedge clk);
        while (!coreReq_ready && n < 100) begin n++; @(negedge clk); end
        if (!coreReq_ready) begin
            nCmp++; nBad++;
            $display("FAIL push_timeout: got ready=0, required ready=1 within 100 cycles");
        end else issueQ.push_back('{w, node, addr, d});
        @(posedge clk); #1 coreReq_valid = 1'b0;
    endtask

    task automatic wait_read(input string tag);
        int n = 0;
        @(negedge clk);
        while (!memReadOut && n < 20) begin n++; @(negedge clk); end
        nCmp++;
        if (!memReadOut) begin
            nBad++;
            $display("FAIL %s_issue: got memReadOut=0, required 1 within 20 cycles", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nCmp++;
        if ({coreReq_ready, coreResp_valid, coreResp_error, writeDone, busy, memReadOut, memWriteOut} !== 7'b0 ||
            coreResp_data !== 32'h0 || targetAddressOut !== 8'h0 || cacheAddressOut !== 10'h0 || dataOut !== 32'h0) begin
            nBad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b rd=%b wr=%b data=%h, required all 0",
                     coreReq_ready, coreResp_valid, busy, memReadOut, memWriteOut, coreResp_data);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        nCmp++;
        if (coreReq_ready !== 1'b1 || busy !== 1'b0) begin
            nBad++;
            $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", coreReq_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        netReady = 1'b1;
        respQ.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        push_req(1'b0, 8'd3, 10'h005, 32'h0);
        @(negedge clk);
        nCmp++;
        if (memReadOut !== 1'b0) begin
            nBad++; $display("FAIL load_latency_early: got memReadOut=%b, required 0 one cycle after push", memReadOut);
        end
        @(negedge clk);
        nCmp++;
        if (memReadOut !== 1'b1) begin
            nBad++; $display("FAIL load_latency: got memReadOut=%b, required 1 two cycles after push", memReadOut);
        end
        repeat (3) @(posedge clk);
        #1 readReadyIn = 1'b1; requesterAddressIn = MY; cacheDataIn = 32'hDEADBEEF;
        @(negedge clk);
        nCmp++;
        if (memReadOut !== 1'b0 || coreResp_valid !== 1'b0) begin
            nBad++; $display("FAIL load_wait: got rd=%b v=%b, required rd=0 v=0", memReadOut, coreResp_valid);
        end
        @(posedge clk); #1 readReadyIn = 1'b0;
        @(negedge clk);
        nCmp++;
        if (coreResp_valid !== 1'b1) begin
            nBad++; $display("FAIL load_resp_latency: got valid=%b, required 1 one cycle after match", coreResp_valid);
        end
        begin
            int extra = 0;
            repeat (6) begin @(negedge clk); extra += int'(coreResp_valid) + int'(memReadOut); end
            nCmp++;
            if (extra != 0 || coreResp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
                nBad++;
                $display("FAIL load_after: got extra=%0d data=%h busy=%b, required 0 DEADBEEF 0", extra, coreResp_data, busy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int done = 0;
        netReady = 1'b0;
        // first store is parked in ISSUE, so the next four fill the queue
        for (int i = 0; i < 5; i++) begin
            coreReq_valid = 1'b1; coreReq_write = 1'b1; coreReq_bankNode = 8'd7;
            coreReq_address = 10'(i * 16 + 1); coreReq_data = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            nCmp++;
            if (coreReq_ready !== 1'b1) begin
                nBad++; $display("FAIL b2b_accept%0d: got ready=%b, required 1", i, coreReq_ready);
            end
            issueQ.push_back('{1'b1, 8'd7, 10'(i * 16 + 1), 32'hA000_0000 + 32'(i)});
            respQ.push_back('{1'b1, 32'h0, 1'b0});
            @(posedge clk); #1;
        end
        coreReq_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            nCmp++;
            if (coreReq_ready !== 1'b0 || memWriteOut !== 1'b1 || dataOut !== 32'hA000_0000) begin
                nBad++;
                $display("FAIL b2b_full: got ready=%b wr=%b data=%h, required 0 1 A0000000", coreReq_ready, memWriteOut, dataOut);
            end
        end
        @(posedge clk); #1 netReady = 1'b1;
        for (int i = 0; i < 60 && done < 5; i++) begin
            @(negedge clk);
            if (writeDone) done++;
        end
        repeat (2) @(negedge clk);
        nCmp++;
        if (done != 5 || busy !== 1'b0 || coreReq_ready !== 1'b1) begin
            nBad++; $display("FAIL b2b_drain: got writeDone=%0d busy=%b ready=%b, required 5 0 1", done, busy, coreReq_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int iss[4];
        int nIss = 0, respCyc = -1;
        netReady = 1'b1;
        respQ.push_back('{1'b0, 32'h0, 1'b1});
        push_req(1'b0, 8'd2, 10'h3FF, 32'h0);
        issueQ.push_back('{1'b0, 8'd2, 10'h3FF, 32'h0});
        issueQ.push_back('{1'b0, 8'd2, 10'h3FF, 32'h0});
        for (int i = 0; i < 400 && respCyc < 0; i++) begin
            @(negedge clk);
            if (memReadOut && nIss < 4) begin iss[nIss] = cyc; nIss++; end
            if (coreResp_valid) respCyc = cyc;
        end
        nCmp++;
        if (nIss != 3 || respCyc < 0) begin
            nBad++; $display("FAIL timeout_count: got issues=%0d resp=%0d, required 3 issues and a response", nIss, respCyc);
        end else begin
            nCmp++;
            if (iss[1] - iss[0] != TMO + 1 || iss[2] - iss[1] != TMO + 1 || respCyc - iss[2] != TMO + 1) begin
                nBad++;
                $display("FAIL timeout_spacing: got %0d %0d %0d, required %0d each",
                         iss[1] - iss[0], iss[2] - iss[1], respCyc - iss[2], TMO + 1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_foreign();
        netReady = 1'b1;
        respQ.push_back('{1'b0, 32'h0000_1234, 1'b0});
        push_req(1'b0, 8'd4, 10'h012, 32'h0);
        wait_read("foreign");
        @(posedge clk); #1 readReadyIn = 1'b1; requesterAddressIn = MY + 8'd1; cacheDataIn = 32'hBAD0_BAD0;
        @(posedge clk); #1 readReadyIn = 1'b0;
        @(negedge clk);
        nCmp++;
        if (coreResp_valid !== 1'b0 || busy !== 1'b1 || coreResp_data !== 32'h0) begin
            nBad++;
            $display("FAIL foreign_ignored: got v=%b busy=%b data=%h, required 0 1 00000000", coreResp_valid, busy, coreResp_data);
        end
        @(posedge clk); #1 readReadyIn = 1'b1; requesterAddressIn = MY; cacheDataIn = 32'h0000_1234;
        @(posedge clk); #1 readReadyIn = 1'b0;
        @(negedge clk);
        nCmp++;
        if (coreResp_valid !== 1'b1 || coreResp_data !== 32'h0000_1234) begin
            nBad++; $display("FAIL foreign_match: got v=%b data=%h, required 1 00001234", coreResp_valid, coreResp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout_match();
        int reiss = 0;
        netReady = 1'b1;
        respQ.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
        push_req(1'b0, 8'd1, 10'h020, 32'h0);
        wait_read("tmatch");
        // the 64th WAIT cycle is the one that would otherwise reissue
        repeat (TMO) @(posedge clk);
        #1 readReadyIn = 1'b1; requesterAddressIn = MY; cacheDataIn = 32'hCAFE_F00D;
        @(posedge clk); #1 readReadyIn = 1'b0;
        @(negedge clk);
        nCmp++;
        if (coreResp_valid !== 1'b1 || coreResp_error !== 1'b0) begin
            nBad++; $display("FAIL tmatch_resp: got v=%b err=%b, required 1 0", coreResp_valid, coreResp_error);
        end
        repeat (TMO + 6) begin @(negedge clk); if (memReadOut) reiss++; end
        nCmp++;
        if (reiss != 0) begin
            nBad++; $display("FAIL tmatch_reissue: got %0d reissue cycles, required 0", reiss);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        netReady = 1'b1;
        push_req(1'b0, 8'd6, 10'h001, 32'h0);
        wait_read("rstwait");
        @(posedge clk); #1;
        push_req(1'b0, 8'd6, 10'h002, 32'h0);
        push_req(1'b0, 8'd6, 10'h003, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        nCmp++;
        if ({coreReq_ready, busy, memReadOut, memWriteOut, coreResp_valid, writeDone} !== 6'b0 || coreResp_data !== 32'h0) begin
            nBad++;
            $display("FAIL rstwait_outputs: got rdy=%b busy=%b rd=%b v=%b data=%h, required all 0",
                     coreReq_ready, busy, memReadOut, coreResp_valid, coreResp_data);
        end
        @(posedge clk); #1 reset = 1'b0;
        issueQ.delete();
        respQ.delete();
        readReadyIn = 1'b1; requesterAddressIn = MY; cacheDataIn = 32'h5555_5555;
        @(posedge clk); #1 readReadyIn = 1'b0;
        repeat (10) begin @(negedge clk); seen += int'(coreResp_valid) + int'(busy) + int'(memReadOut); end
        nCmp++;
        if (seen != 0) begin
            nBad++; $display("FAIL rstwait_after: got %0d active valid/busy/read cycles, required 0", seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_timeout();
        test_foreign();
        test_timeout_match();
        test_reset_wait();
        repeat (3) @(negedge clk);
        nCmp++;
        if (issueQ.size() != 0 || respQ.size() != 0) begin
            nBad++; $display("FAIL scoreboard_drain: got %0d issues %0d responses left, required 0 0", issueQ.size(), respQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
